// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS main control FSM
//   state_t      : FSM state numbering, also exported on the debug state port
//   OP_* / FN_*  : opcode and funct constants recognised by the decoder
//   ALU_* / PCS_* / SRCB_* : alu_op, pc_source and alu_src_b encodings
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
      S_MDWAIT = 4'd12
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_SHIFT = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_IMM = 2'b11;
   localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10;
   localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
   // States that own the shared memory port and can stall on mem_ready
   function automatic logic is_mem_state(state_t s);
      return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
   endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags when WAIT_MAX is reached
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the count (has priority over en)
//   en         : advance the count by one
//   expired    : count equals WAIT_MAX
module mem_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(WAIT_MAX + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
   assign expired = cnt_q == CW'(WAIT_MAX);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core
//   inputs : clk, reset (sync, active-high), opcode, funct, mem_ready,
//            muldiv_done (MULDIV_EN builds only)
//   outputs: PC control (pc_write, pc_write_cond, branch_ne, pc_source),
//            memory (i_or_d, mem_read, mem_write, ir_write), register file
//            (reg_dst, mem_to_reg, reg_write), ALU (alu_src_a, alu_src_b, alu_op),
//            pulses illegal_op / bus_error, muldiv_start (MULDIV_EN), debug state
//   `define MULDIV_EN adds the mult/div start/wait handshake and the MDWAIT state
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALU_OP_W = 2,
   parameter int WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [OPCODE_W-1:0] funct,
   input  logic                mem_ready,
`ifdef MULDIV_EN
   input  logic                muldiv_done,
   output logic                muldiv_start,
`endif
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                branch_ne,
   output logic [1:0]          pc_source,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal_op,
   output logic                bus_error,
   output logic [3:0]          state
);
   state_t state_q, state_d;
   logic op_rtype, op_shift, op_lw, op_sw, op_br, op_j, op_imm, op_legal;
   logic mem_st, expired, timeout, tmr_clr, tmr_en;
   assign op_rtype = opcode == OPCODE_W'(OP_RTYPE);
   assign op_shift = opcode == OPCODE_W'(OP_SHIFT);
   assign op_lw    = opcode == OPCODE_W'(OP_LW);
   assign op_sw    = opcode == OPCODE_W'(OP_SW);
   assign op_br    = (opcode >> 1) == OPCODE_W'(OP_BEQ >> 1);
   assign op_j     = opcode == OPCODE_W'(OP_J);
   assign op_imm   = (opcode >> 3) == OPCODE_W'(OP_ADDI >> 3);
   assign op_legal = op_rtype | op_shift | op_lw | op_sw | op_br | op_j | op_imm;
`ifdef MULDIV_EN
   logic is_md;
   assign is_md = op_rtype & (funct == OPCODE_W'(FN_MULT) | funct == OPCODE_W'(FN_DIV));
`else
   logic unused_funct;
   assign unused_funct = ^funct;
`endif
   // The count restarts whenever the port is not stalled, so every memory
   // state is entered with a zero count and a timeout retries from scratch.
   assign mem_st  = is_mem_state(state_q);
   assign tmr_en  = mem_st & ~mem_ready;
   assign tmr_clr = ~tmr_en | expired;
   assign timeout = tmr_en & expired;
   mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expired(expired)
   );
   always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_d = (op_rtype | op_shift) ? S_RTEXEC :
                             (op_lw | op_sw)       ? S_MEMADR :
                             op_br                 ? S_BRANCH :
                             op_j                  ? S_JUMP   :
                             op_imm                ? S_IEXEC  : S_FETCH;
         S_MEMADR: state_d = op_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : timeout ? S_FETCH : S_MEMRD;
         S_MEMWR:  state_d = (mem_ready | timeout) ? S_FETCH : S_MEMWR;
`ifdef MULDIV_EN
         S_RTEXEC: state_d = is_md ? S_MDWAIT : S_RTWB;
         S_MDWAIT: state_d = muldiv_done ? S_RTWB : S_MDWAIT;
`else
         S_RTEXEC: state_d = S_RTWB;
`endif
         S_IEXEC:  state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end
   // Everything is held at zero while reset is high, so an aborted
   // instruction cannot leak a write enable in the reset cycle.
   always_comb begin
      {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write} = '0;
      {reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, bus_error} = '0;
      pc_source = PCS_ALU;
      alu_src_b = SRCB_RT;
      alu_op    = ALU_OP_W'(ALU_ADD);
`ifdef MULDIV_EN
      muldiv_start = 1'b0;
`endif
      if (!reset) begin
         bus_error = timeout;
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b  = SRCB_IMM_SH2;
               illegal_op = ~op_legal;
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               mem_write = ~timeout;
               i_or_d    = 1'b1;
            end
            S_RTEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = op_shift ? SRCB_IMM : SRCB_RT;
               alu_op    = ALU_OP_W'(ALU_FUNCT);
`ifdef MULDIV_EN
               muldiv_start = is_md;
`endif
            end
            S_RTWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_OP_W'(ALU_SUB);
               pc_write_cond = 1'b1;
               pc_source     = PCS_ALUOUT;
               branch_ne     = opcode[0];
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PCS_JUMP;
            end
            S_IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_OP_W'(opcode == OPCODE_W'(OP_ADDI) ? ALU_ADD : ALU_IMM);
            end
            S_IWB: reg_write = 1'b1;
            default: ;
         endcase
      end
   end
   assign state = reset ? 4'(S_FETCH) : 4'(state_q);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized bench against an instruction-level model of the control FSM
module tb_multicycle_control;
   localparam int WAIT_MAX = 15;
`ifdef MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int B_MDS = 23, B_PCW = 22, B_PWC = 21, B_BNE = 20, B_PCS = 18, B_IOD = 17;
   localparam int B_MRD = 16, B_MWR = 15, B_IRW = 14, B_RDST = 13, B_M2R = 12, B_RW = 11;
   localparam int B_SA = 10, B_SB = 8, B_AOP = 6, B_ILL = 5, B_BE = 4;
   logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0, muldiv_done = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, bus_error, mds;
   logic [1:0] pc_source, alu_src_b, alu_op;
   logic [3:0] state;
   int checks = 0, failures = 0;
   int plan[$];
   int w = 0;
   always #5 clk = ~clk;
   multicycle_control #(.OPCODE_W(6), .ALU_OP_W(2), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
`ifdef MULDIV_EN
      .muldiv_done(muldiv_done), .muldiv_start(mds),
`endif
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
   );
`ifndef MULDIV_EN
   assign mds = 1'b0;
`endif
   wire [23:0] got_v = {mds, pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
                        mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                        alu_src_b, alu_op, illegal_op, bus_error, state};
   function automatic bit legal(logic [5:0] op);
      casez (op)
         6'b000000, 6'b110000, 6'b100011, 6'b101011, 6'b00010?, 6'b000010, 6'b001???: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   function automatic bit is_md(logic [5:0] op, logic [5:0] f);
      return MD && op == 6'b000000 && (f == 6'b011000 || f == 6'b011010);
   endfunction
   function automatic bit mem_phase(int ph);
      return ph == 0 || ph == 3 || ph == 5;
   endfunction
   // Expected outputs for one cycle of a given instruction phase
   function automatic logic [23:0] expect_out(int ph, logic [5:0] op, logic [5:0] f, logic mr, int wc, logic rst);
      logic [23:0] e;
      logic to;
      e = '0;
      if (rst) return e;
      to = mem_phase(ph) && !mr && wc == WAIT_MAX;
      e[3:0] = 4'(ph);
      e[B_BE] = to;
      case (ph)
         0: begin e[B_MRD] = 1'b1; e[B_SB+:2] = 2'b01; e[B_IRW] = mr; e[B_PCW] = mr; end
         1: begin e[B_SB+:2] = 2'b11; e[B_ILL] = !legal(op); end
         2: begin e[B_SA] = 1'b1; e[B_SB+:2] = 2'b10; end
         3: begin e[B_MRD] = 1'b1; e[B_IOD] = 1'b1; end
         4: begin e[B_RW] = 1'b1; e[B_M2R] = 1'b1; end
         5: begin e[B_MWR] = !to; e[B_IOD] = 1'b1; end
         6: begin
            e[B_SA] = 1'b1; e[B_AOP+:2] = 2'b10;
            e[B_SB+:2] = (op == 6'b110000) ? 2'b10 : 2'b00;
            e[B_MDS] = is_md(op, f);
         end
         7: begin e[B_RW] = 1'b1; e[B_RDST] = 1'b1; end
         8: begin e[B_SA] = 1'b1; e[B_AOP+:2] = 2'b01; e[B_PWC] = 1'b1; e[B_PCS+:2] = 2'b01; e[B_BNE] = op[0]; end
         9: begin e[B_PCW] = 1'b1; e[B_PCS+:2] = 2'b10; end
         10: begin e[B_SA] = 1'b1; e[B_SB+:2] = 2'b10; e[B_AOP+:2] = (op == 6'b001000) ? 2'b00 : 2'b11; end
         11: e[B_RW] = 1'b1;
         default: ;
      endcase
      return e;
   endfunction
   // Advance the instruction plan: plan[0] is the phase the next cycle occupies
   task automatic model_step(logic rst, logic mr, logic [5:0] op, logic [5:0] f, logic done);
      int cur;
      if (rst) begin plan.delete(); plan.push_back(0); w = 0; return; end
      cur = plan[0];
      if (mem_phase(cur) && !mr) begin
         if (w == WAIT_MAX) begin plan.delete(); plan.push_back(0); w = 0; end
         else w++;
         return;
      end
      if (cur == 12 && !done) return;
      w = 0;
      void'(plan.pop_front());
      if (cur == 0) plan.push_back(1);
      else if (cur == 1) begin
         if (op == 6'b100011) begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
         else if (op == 6'b101011) begin plan.push_back(2); plan.push_back(5); end
         else if (op == 6'b000000 || op == 6'b110000) begin
            plan.push_back(6);
            if (is_md(op, f)) plan.push_back(12);
            plan.push_back(7);
         end
         else if (op[5:1] == 5'b00010) plan.push_back(8);
         else if (op == 6'b000010) plan.push_back(9);
         else if (op[5:3] == 3'b001) begin plan.push_back(10); plan.push_back(11); end
      end
      if (plan.size() == 0) plan.push_back(0);
   endtask
   initial plan.push_back(0);
   always @(negedge clk) begin
      logic [23:0] exp_v;
      #1;
      exp_v = expect_out(plan[0], opcode, funct, mem_ready, w, reset);
      checks++;
      if (got_v !== exp_v) begin
         failures++;
         $display("FAIL model_cycle t=%0t phase=%0d got=%h want=%h", $time, plan[0], got_v, exp_v);
      end
      model_step(reset, mem_ready, opcode, funct, muldiv_done);
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic settle();
      @(negedge clk);
      #2;
   endtask
   task automatic drive(input logic r, input logic mr, input logic [5:0] op);
      tick();
      reset = r; mem_ready = mr; opcode = op;
      settle();
   endtask
   function automatic logic [5:0] pick();
      case ($urandom_range(0, 9))
         0: return 6'b000000;
         1: return 6'b110000;
         2: return 6'b100011;
         3: return 6'b101011;
         4: return 6'b000100;
         5: return 6'b000101;
         6: return 6'b000010;
         7: return {3'b001, 3'($urandom)};
         default: return 6'($urandom);
      endcase
   endfunction
   initial begin
      int rt_seq[5] = '{0, 1, 6, 7, 0};
      int lw_seq[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      logic lw_mr[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
      int br_seq[4] = '{0, 1, 8, 0};
      int zrun = 0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 6'b000000);
         chk("reset_outputs_zero", 32'(got_v), 32'd0);
      end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 6'b000000);
         chk("rtype_state", 32'(state), 32'(rt_seq[k]));
         if (k == 3) chk("rtype_wb_regwrite_regdst", 32'({reg_write, reg_dst}), 32'd3);
      end
      drive(1'b1, 1'b0, 6'b100011);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, lw_mr[k], 6'b100011);
         chk("lw_state", 32'(state), 32'(lw_seq[k]));
         if (k == 6) chk("lw_memwb_memtoreg_regwrite", 32'({mem_to_reg, reg_write}), 32'd3);
      end
      drive(1'b1, 1'b0, 6'b000101);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, 6'b000101);
         chk("bne_state", 32'(state), 32'(br_seq[k]));
         if (k == 2) chk("bne_controls", 32'({pc_write_cond, branch_ne, alu_op, pc_source}), 32'b110101);
      end
      drive(1'b1, 1'b0, 6'b000000);
      for (int k = 0; k < 32; k++) begin
         drive(1'b0, 1'b0, 6'b000000);
         chk("timeout_bus_error", 32'(bus_error), 32'(k == 15 || k == 31));
         chk("timeout_no_fetch_write", 32'({ir_write, pc_write, state}), 32'd0);
      end
      drive(1'b1, 1'b0, 6'b111111);
      drive(1'b0, 1'b1, 6'b111111);
      chk("illegal_fetch_state", 32'(state), 32'd0);
      drive(1'b0, 1'b1, 6'b111111);
      chk("illegal_pulse", 32'({illegal_op, state}), 32'h11);
      drive(1'b0, 1'b0, 6'b111111);
      chk("illegal_back_to_fetch", 32'({illegal_op, state}), 32'h00);
      drive(1'b1, 1'b0, 6'b101011);
      drive(1'b0, 1'b1, 6'b101011);
      drive(1'b0, 1'b1, 6'b101011);
      drive(1'b0, 1'b1, 6'b101011);
      drive(1'b0, 1'b0, 6'b101011);
      chk("sw_memwr_write", 32'({mem_write, state}), 32'h15);
      drive(1'b1, 1'b0, 6'b101011);
      chk("sw_reset_abort", 32'({mem_write, state}), 32'h00);
      drive(1'b0, 1'b0, 6'b101011);
      chk("sw_after_reset_fetch", 32'({mem_read, mem_write, state}), 32'h20);
`ifdef MULDIV_EN
      drive(1'b1, 1'b0, 6'b000000);
      funct = 6'b011010;
      muldiv_done = 1'b0;
      drive(1'b0, 1'b1, 6'b000000);
      drive(1'b0, 1'b1, 6'b000000);
      drive(1'b0, 1'b1, 6'b000000);
      chk("md_start_pulse", 32'({mds, state}), 32'h16);
      for (int k = 0; k < 5; k++) begin
         tick();
         muldiv_done = (k == 4);
         settle();
         chk("md_wait_state", 32'({mds, state}), 32'd12);
      end
      drive(1'b0, 1'b1, 6'b000000);
      chk("md_rtwb", 32'({mds, reg_write, reg_dst, state}), 32'h37);
      muldiv_done = 1'b0;
      funct = 6'b000000;
`endif
      for (int i = 0; i < 4000; i++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         if (zrun > 0) begin mem_ready = 1'b0; zrun--; end
         else if ($urandom_range(0, 99) == 0) begin mem_ready = 1'b0; zrun = 20; end
         else mem_ready = ($urandom_range(0, 3) != 0);
         muldiv_done = ($urandom_range(0, 3) == 0);
         if (plan[0] == 0) begin
            opcode = pick();
            funct = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 6'b011000 : 6'b011010) : 6'($urandom);
         end
         settle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
